clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//   Measures a divided/derived clock signal against the system clock: period and high time in clk
//   cycles, checked against an expected period. Raises lock, mismatch and stuck flags.
//   Sits beside a clock divider as its self-check, in benches and in the FPGA top level.
// PARAMETERS
//   EXP_PERIOD  8    expected period of sig_in, in clk cycles (>=2)
//   TOL         0    allowed |period - EXP_PERIOD| still counted as a match
//   LOCK_COUNT  4    consecutive matching periods needed to assert locked
//   MAX_PERIOD  255  cycles without a rising edge before stuck is asserted
//   CNT_W       $clog2(MAX_PERIOD+1)  width of the period/high counters (derived, do not override)
// PORTS
//   clk         in   1      system clock, all logic on posedge
//   rst         in   1      asynchronous, active-high reset
//   sig_in      in   1      measured signal, synchronous to clk (produced from clk)
//   period      out  CNT_W  last measured period, rising edge to rising edge
//   high_time   out  CNT_W  high cycles within the last measured period
//   meas_valid  out  1      1-cycle pulse when period/high_time update
//   locked      out  1      LOCK_COUNT consecutive periods within tolerance
//   mismatch    out  1      1-cycle pulse on an out-of-tolerance period
//   stuck       out  1      no rising edge for MAX_PERIOD cycles; sticky until next edge
//   err_cnt     out  8      saturating count of mismatches since reset
// BEHAVIOUR
//   - Reset: all outputs 0, internal counters 0, state IDLE, s1/s2 = 0.
//   - Sampling: s1 <= sig_in; s2 <= s1; rise = s1 & ~s2. Detection lags the input edge by 1 clk.
//   - Counter cnt: on rise, cnt <= 1; else if cnt < MAX_PERIOD, cnt <= cnt+1 (saturates).
//     hi: on rise, hi <= 1; else if s1, hi <= hi+1 (saturating). On rise, cnt/hi hold the full
//     previous period/high time.
//   - FSM states IDLE, FIRST, RUN:
//       IDLE : wait for rise -> FIRST (counters start, nothing reported).
//       FIRST: next rise -> RUN, report the first period (meas_valid=1).
//       RUN  : every rise reports: period<=cnt, high_time<=hi, meas_valid=1.
//       FIRST/RUN: cnt==MAX_PERIOD and no rise -> stuck<=1, locked<=0, match run <=0, -> IDLE.
//       Any rise clears stuck.
//   - Match check on every report: match = |cnt - EXP_PERIOD| <= TOL (unsigned, compare widened
//     to CNT_W+1). A match increments run (saturates at LOCK_COUNT); run==LOCK_COUNT sets locked
//     in the same cycle the report is registered. A mismatch pulses mismatch, sets run<=0 and
//     locked<=0, and increments err_cnt (saturates at 255).
//   - Report latency: period/high_time/flags are valid the cycle after rise is seen, i.e. two clk
//     after the sig_in rising edge.
//   - Glitch: a 1-cycle pulse still counts as an edge and yields a short period (mismatch).
//   - Constant sig_in (0 or 1): stuck after MAX_PERIOD cycles. Outputs keep their last values,
//     except locked, which goes to 0.
//   - Simultaneous rise and cnt reaching MAX_PERIOD: rise wins, report with period = MAX_PERIOD,
//     no stuck.
//   - rst mid-measurement clears everything immediately. The first report after release needs
//     two fresh rising edges.
// STRUCTURE
//   - Shared package clk_meas_pkg: FSM state encoding (IDLE/FIRST/RUN), the err_cnt width
//     constant, and a sat_inc helper function.
//   - One sub-module, edge_detect (s1/s2 registers, rise/fall outputs). Reused by other blocks.
//   - All else (counters, FSM, match/lock logic) stays in this module.
// TESTING
//   - Reset held 10 clk, sig_in toggling -> all outputs 0 during reset, no meas_valid.
//   - 50% square wave, period 8 (4 high / 4 low), defaults -> first report period=8,
//     high_time=4; locked=1 on 4th match; err_cnt=0.
//   - After lock, one period of 10 -> mismatch pulse, locked=0, err_cnt=1; relocks after 4 more
//     periods of 8.
//   - TOL=1, periods alternating 7/9 -> no mismatch, locked after 4 reports.
//   - sig_in held 0 after lock -> stuck=1 and locked=0 exactly 255 clk after the last detected
//     rise. The next rise clears stuck, and the following rise reports again.
//   - Assert rst between two edges while locked, then resume period 8 -> first report on the
//     2nd edge after release; err_cnt restarts from 0.

Source files
------------

// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock period meter family.
// Holds the measurement FSM encoding, the error counter width and a saturating increment.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2
  } meas_state_e;

  localparam int ERR_W = 8;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ERR_W'(1'b1);
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-stage sampler of a clk-synchronous signal with rise/fall strobes.
// The strobes lag the input transition by one clk.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;

  // sample history used to find transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
    end
  end

  assign level = s1_r;
  assign rise  = s1_r & ~s2_r;
  assign fall  = ~s1_r & s2_r;

endmodule

// File: rtl/clk_period_meter.sv
// Self-check for a derived clock: measures period and high time of sig_in in clk cycles,
// compares against EXP_PERIOD and reports lock, mismatch and stuck status.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int EXP_PERIOD = 8,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_PERIOD = 255,
  parameter int CNT_W      = $clog2(MAX_PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             stuck,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW1   = CNT_W + 1;
  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_PERIOD);
  localparam logic [CW1-1:0]   EXP_C  = CW1'(EXP_PERIOD);
  localparam logic [CW1-1:0]   TOL_C  = CW1'(TOL);
  localparam logic [RUN_W-1:0] LOCK_C = RUN_W'(LOCK_COUNT);

  logic             level_s;
  logic             rise_s;
  logic             fall_unused_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] hi_r;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_nxt_s;
  logic [CW1-1:0]   cnt_wide_s;
  logic [CW1-1:0]   diff_s;
  logic             match_s;
  meas_state_e      state_r;

  edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .level  (level_s),
    .rise   (rise_s),
    .fall   (fall_unused_s)
  );

  // period and high-time counters, restarted by every detected rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      hi_r  <= '0;
    end else begin
      if (rise_s) begin
        cnt_r <= CNT_W'(1'b1);
      end else if (cnt_r < MAX_C) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (rise_s) begin
        hi_r <= CNT_W'(1'b1);
      end else if (level_s && (hi_r < MAX_C)) begin
        hi_r <= hi_r + CNT_W'(1'b1);
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  // tolerance check on the just-completed period and next match-run value
  always_comb begin
    cnt_wide_s = {1'b0, cnt_r};
    diff_s     = '0;
    run_nxt_s  = run_r;
    if (cnt_wide_s >= EXP_C) begin
      diff_s = cnt_wide_s - EXP_C;
    end else begin
      diff_s = EXP_C - cnt_wide_s;
    end
    match_s = (diff_s <= TOL_C);
    if (run_r < LOCK_C) begin
      run_nxt_s = run_r + RUN_W'(1'b1);
    end else begin
      run_nxt_s = run_r;
    end
  end

  // measurement FSM with registered report, lock and error outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      stuck      <= 1'b0;
      err_cnt    <= '0;
      run_r      <= '0;
    end else begin
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            stuck   <= 1'b0;
            state_r <= ST_FIRST;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FIRST, ST_RUN: begin
          // a rise coinciding with counter saturation still reports
          if (rise_s) begin
            stuck      <= 1'b0;
            state_r    <= ST_RUN;
            period     <= cnt_r;
            high_time  <= hi_r;
            meas_valid <= 1'b1;
            if (match_s) begin
              run_r  <= run_nxt_s;
              locked <= (run_nxt_s == LOCK_C);
            end else begin
              mismatch <= 1'b1;
              run_r    <= '0;
              locked   <= 1'b0;
              err_cnt  <= sat_inc(err_cnt);
            end
          end else if (cnt_r == MAX_C) begin
            stuck   <= 1'b1;
            locked  <= 1'b0;
            run_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: default instance plus a TOL=1 instance.
module tb_clk_period_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig0 = 1'b0;
  logic       sig1 = 1'b0;
  logic [7:0] per0, hi0, per1, hi1, err0, err1;
  logic       mv0, lk0, mm0, st0, mv1, lk1, mm1, st1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rep0 = 0, n_mis0 = 0, n_rep1 = 0, n_mis1 = 0;
  int last_p0 = 0, last_h0 = 0, last_p1 = 0;
  int base_rep, base_mis;
  logic any_out;

  always #5 clk = ~clk;

  clk_period_meter dut0 (
    .clk(clk), .rst(rst), .sig_in(sig0), .period(per0), .high_time(hi0),
    .meas_valid(mv0), .locked(lk0), .mismatch(mm0), .stuck(st0), .err_cnt(err0)
  );

  clk_period_meter #(.TOL(1)) dut1 (
    .clk(clk), .rst(rst), .sig_in(sig1), .period(per1), .high_time(hi1),
    .meas_valid(mv1), .locked(lk1), .mismatch(mm1), .stuck(st1), .err_cnt(err1)
  );

  always @(negedge clk) begin
    if (mv0) begin
      n_rep0 = n_rep0 + 1;
      last_p0 = int'(per0);
      last_h0 = int'(hi0);
    end
    if (mm0) n_mis0 = n_mis0 + 1;
    if (mv1) begin
      n_rep1 = n_rep1 + 1;
      last_p1 = int'(per1);
    end
    if (mm1) n_mis1 = n_mis1 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wave(input int which, input int h, input int l);
    for (int i = 0; i < h + l; i++) begin
      if (which == 0) sig0 = (i < h);
      else            sig1 = (i < h);
      step();
    end
  endtask

  initial begin
    // reset held 10 clk with sig0 toggling
    any_out = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sig0 = ~sig0;
      step();
      any_out = any_out | mv0 | lk0 | mm0 | st0 | (|per0) | (|hi0) | (|err0)
                        | mv1 | lk1 | mm1 | st1 | (|per1) | (|hi1) | (|err1);
    end
    check("rst_outputs_zero", any_out, 0);
    check("rst_no_reports", n_rep0 + n_rep1, 0);
    sig0 = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // TOL=1 instance, periods 7/9/7/9/7
    for (int k = 0; k < 4; k++) wave(1, 4, (k % 2 == 0) ? 3 : 5);
    check("tol_not_locked_3", lk1, 0);
    wave(1, 4, 3);
    check("tol_locked_4", lk1, 1);
    check("tol_reports", n_rep1, 4);
    check("tol_no_mismatch", n_mis1, 0);
    check("tol_last_period", last_p1, 9);
    check("tol_err_cnt", err1, 0);

    // square wave of period 8
    for (int k = 0; k < 4; k++) wave(0, 4, 4);
    check("sq_not_locked_3", lk0, 0);
    wave(0, 4, 4);
    check("sq_reports", n_rep0, 4);
    check("sq_period", last_p0, 8);
    check("sq_high_time", last_h0, 4);
    check("sq_locked_4", lk0, 1);
    check("sq_err_cnt", err0, 0);
    check("sq_no_mismatch", n_mis0, 0);

    // one period of 10 after lock
    base_mis = n_mis0;
    wave(0, 5, 5);
    wave(0, 4, 4);
    check("long_mismatch_pulses", n_mis0 - base_mis, 1);
    check("long_period", last_p0, 10);
    check("long_high_time", last_h0, 5);
    check("long_unlocked", lk0, 0);
    check("long_err_cnt", err0, 1);
    for (int k = 0; k < 3; k++) wave(0, 4, 4);
    check("relock_not_yet", lk0, 0);
    wave(0, 4, 4);
    check("relock_locked", lk0, 1);

    // sig0 held low: stuck 255 clk after the last rise is seen
    for (int i = 0; i < 248; i++) step();
    check("stuck_not_early", st0, 0);
    check("lock_held_early", lk0, 1);
    step();
    check("stuck_set", st0, 1);
    check("stuck_unlocks", lk0, 0);
    check("stuck_keeps_period", per0, 8);
    base_rep = n_rep0;
    wave(0, 4, 4);
    check("stuck_cleared", st0, 0);
    check("stuck_rise_no_report", n_rep0 - base_rep, 0);
    wave(0, 4, 4);
    check("stuck_resume_report", n_rep0 - base_rep, 1);
    check("stuck_resume_period", last_p0, 8);

    // reset mid-measurement while locked
    for (int k = 0; k < 3; k++) wave(0, 4, 4);
    check("pre_rst_locked", lk0, 1);
    sig0 = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst_clears_locked", lk0, 0);
    check("rst_clears_period", per0, 0);
    check("rst_clears_err", err0, 0);
    step();
    sig0 = 1'b0;
    step();
    rst = 1'b0;
    step();
    step();
    base_rep = n_rep0;
    wave(0, 4, 4);
    check("post_rst_first_edge", n_rep0 - base_rep, 0);
    wave(0, 4, 4);
    check("post_rst_second_edge", n_rep0 - base_rep, 1);
    check("post_rst_period", last_p0, 8);
    check("post_rst_err_cnt", err0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
